// File: rtl/sid_pkg.sv
// Shared types, rate table and level-dependent exponential period for the
// SID ADSR envelope generator.
package sid_pkg;

  typedef enum logic [1:0] {
    ATTACK        = 2'd0,
    DECAY_SUSTAIN = 2'd1,
    RELEASE       = 2'd2
  } env_state_t;

  localparam int RATE_W = 15;
  localparam int EXP_W  = 5;

  // Cycles between rate steps, indexed by the 4-bit rate nibble.
  localparam logic [RATE_W-1:0] RATE_PERIOD [0:15] = '{
    15'd9,    15'd32,   15'd63,   15'd95,
    15'd149,  15'd220,  15'd267,  15'd313,
    15'd392,  15'd977,  15'd1954, 15'd3126,
    15'd3907, 15'd11720, 15'd19532, 15'd31251
  };

  // Rate steps per envelope decrement; lower levels fall more slowly to
  // approximate an exponential curve.
  function automatic logic [EXP_W-1:0] exp_period(input logic [7:0] level);
    if (level >= 8'h5e)      return 5'd1;
    else if (level >= 8'h37) return 5'd2;
    else if (level >= 8'h1b) return 5'd4;
    else if (level >= 8'h0f) return 5'd8;
    else if (level >= 8'h07) return 5'd16;
    else if (level >= 8'h01) return 5'd30;
    else                     return 5'd1;
  endfunction

endpackage

// File: rtl/sid_env_rate_counter.sv
// 15-bit rate prescaler: pulses step once every `period` cycles and never
// wraps when the period shrinks below the current count.
module sid_env_rate_counter
  import sid_pkg::*;
(
  input  logic              clock,
  input  logic              reset,
  input  logic              clear,
  input  logic [RATE_W-1:0] period,
  output logic              step
);

  logic [RATE_W-1:0] cnt;
  logic [RATE_W-1:0] cnt_inc;

  assign cnt_inc = cnt + 15'd1;
  assign step    = (cnt_inc == period);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clock) begin
    if (reset || clear) begin
      cnt <= '0;
    end else if (cnt_inc >= period) begin
      // Equal: normal step. Greater: the rate index just dropped, restart.
      cnt <= '0;
    end else begin
      cnt <= cnt_inc;
    end
  end

endmodule

// File: rtl/sid_envelope.sv
// Per-voice SID ADSR envelope: linear attack, exponential decay/release,
// 4-bit sustain level; one clock edge per SID cycle.
module sid_envelope
  import sid_pkg::*;
(
  input  logic       clock,
  input  logic       reset,
  input  logic       gate,
  input  logic [7:0] att_dec,
  input  logic [7:0] sus_rel,
  output logic [7:0] envelope
);

  env_state_t       state;
  env_state_t       state_next;
  logic             gate_prev;
  logic [EXP_W-1:0] exp_cnt;
  logic [EXP_W-1:0] exp_cnt_next;
  logic [EXP_W-1:0] exp_inc;
  logic [7:0]       env_next;
  logic [7:0]       sustain_level;
  logic [7:0]       decay_floor;
  logic [3:0]       rate_idx;
  logic             key_on;
  logic             key_off;
  logic             gate_edge;
  logic             step;

  assign key_on        = gate & ~gate_prev;
  assign key_off       = ~gate & gate_prev;
  assign gate_edge     = key_on | key_off;
  assign sustain_level = {sus_rel[7:4], sus_rel[7:4]};
  assign decay_floor   = (state == DECAY_SUSTAIN) ? sustain_level : 8'h00;
  assign exp_inc       = exp_cnt + 5'd1;

  always_comb begin
    case (state)
      ATTACK:        rate_idx = att_dec[7:4];
      DECAY_SUSTAIN: rate_idx = att_dec[3:0];
      default:       rate_idx = sus_rel[3:0];
    endcase
  end

  sid_env_rate_counter u_rate_counter (
    .clock  (clock),
    .reset  (reset),
    .clear  (gate_edge),
    .period (RATE_PERIOD[rate_idx]),
    .step   (step)
  );

  // NOTE: every output of this block gets a default first; a path that
  // left one unassigned would infer a latch.
  always_comb begin
    state_next   = state;
    env_next     = envelope;
    exp_cnt_next = exp_cnt;

    if (key_on) begin
      state_next   = ATTACK;
      exp_cnt_next = '0;
    end else if (key_off) begin
      state_next   = RELEASE;
      exp_cnt_next = '0;
    end else if (step) begin
      case (state)
        ATTACK: begin
          exp_cnt_next = '0;
          if (envelope != 8'hff) env_next = envelope + 8'd1;
          if (envelope >= 8'hfe) state_next = DECAY_SUSTAIN;
        end
        DECAY_SUSTAIN, RELEASE: begin
          if (exp_inc >= exp_period(envelope)) begin
            exp_cnt_next = '0;
            // Only falls toward the floor; a raised sustain never pulls up.
            if (envelope > decay_floor) env_next = envelope - 8'd1;
          end else begin
            exp_cnt_next = exp_inc;
          end
        end
        default: state_next = RELEASE;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= RELEASE;
      envelope  <= 8'h00;
      exp_cnt   <= '0;
      // Track the live gate so a gate held high through reset is not
      // mistaken for a new key-on once reset drops.
      gate_prev <= gate;
    end else begin
      state     <= state_next;
      envelope  <= env_next;
      exp_cnt   <= exp_cnt_next;
      gate_prev <= gate;
    end
  end

endmodule

// File: tb/tb_sid_envelope.sv
// Directed bench for sid_envelope: table-driven attack timing plus
// hand-written decay, release, retrigger, rate-change and reset sequences.
module tb_sid_envelope;
  import sid_pkg::*;

  logic       clock = 1'b0;
  logic       reset;
  logic       gate;
  logic [7:0] att_dec;
  logic [7:0] sus_rel;
  logic [7:0] envelope;

  int n_checks = 0;
  int n_fail   = 0;

  sid_envelope dut (
    .clock    (clock),
    .reset    (reset),
    .gate     (gate),
    .att_dec  (att_dec),
    .sus_rel  (sus_rel),
    .envelope (envelope)
  );

  always #5 clock = ~clock;

  typedef struct {
    string      name;
    logic       gate;
    logic [7:0] ad;
    logic [7:0] sr;
    int         cycles;
    logic [7:0] exp_env;
  } vec_t;

  vec_t vecs [8];

  task automatic check(input string name, input logic [31:0] actual,
                       input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Advance n rising edges, then settle 1 time unit past the edge.
  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  // Count rising edges until the envelope changes, bounded by limit.
  task automatic wait_change(input int limit, output int n, output bit timeout);
    logic [7:0] prev;
    prev    = envelope;
    n       = 0;
    timeout = 1'b0;
    do begin
      tick(1);
      n++;
    end while (envelope == prev && n < limit);
    timeout = (envelope == prev);
  endtask

  // Reference decrement interval in rate steps for a given level.
  function automatic int ref_exp(input logic [7:0] v);
    if (v == 8'h00)                   return 1;
    if (v inside {[8'h01:8'h06]})     return 30;
    if (v inside {[8'h07:8'h0e]})     return 16;
    if (v inside {[8'h0f:8'h1a]})     return 8;
    if (v inside {[8'h1b:8'h36]})     return 4;
    if (v inside {[8'h37:8'h5d]})     return 2;
    return 1;
  endfunction

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int  n;
    bit  to;
    bit  held;
    logic [7:0] v;

    // Gate rises at edge k after a long idle; P=9 attack reaches 0xFF at k+2295.
    vecs[0] = '{"idle_1000",  1'b0, 8'h00, 8'hf0, 1000, 8'h00};
    vecs[1] = '{"k_plus_8",   1'b1, 8'h00, 8'hf0, 9,    8'h00};
    vecs[2] = '{"k_plus_9",   1'b1, 8'h00, 8'hf0, 1,    8'h01};
    vecs[3] = '{"k_plus_17",  1'b1, 8'h00, 8'hf0, 8,    8'h01};
    vecs[4] = '{"k_plus_18",  1'b1, 8'h00, 8'hf0, 1,    8'h02};
    vecs[5] = '{"k_plus_2294", 1'b1, 8'h00, 8'hf0, 2276, 8'hfe};
    vecs[6] = '{"k_plus_2295", 1'b1, 8'h00, 8'hf0, 1,    8'hff};
    vecs[7] = '{"sustain_ff", 1'b1, 8'h00, 8'hf0, 500,  8'hff};

    reset   = 1'b1;
    gate    = 1'b0;
    att_dec = 8'h00;
    sus_rel = 8'hf0;
    tick(3);
    reset = 1'b0;
    check("reset_envelope", envelope, 8'h00);
    check("reset_state", dut.state, RELEASE);

    for (int i = 0; i < 8; i++) begin
      gate    = vecs[i].gate;
      att_dec = vecs[i].ad;
      sus_rel = vecs[i].sr;
      tick(vecs[i].cycles);
      check(vecs[i].name, envelope, vecs[i].exp_env);
      if (i == 6) check("state_after_peak", dut.state, DECAY_SUSTAIN);
    end

    // Decay to sustain 0x88 at E=1: one step every 9 cycles.
    sus_rel = 8'h80;
    wait_change(20, n, to);
    check("decay_first_timeout", to, 1'b0);
    check("decay_first_value", envelope, 8'hfe);
    for (int lv = 8'hfe; lv > 8'h88; lv--) begin
      wait_change(30, n, to);
      check($sformatf("decay_interval_%0h", lv), n, 9);
      check($sformatf("decay_value_%0h", lv), envelope, lv - 1);
    end
    held = 1'b1;
    for (int c = 0; c < 300; c++) begin
      tick(1);
      if (envelope != 8'h88) held = 1'b0;
    end
    check("sustain_88_hold", held, 1'b1);

    // Release from 0x88 to 0 with sustain 0; first step 9 cycles after the edge.
    gate    = 1'b0;
    sus_rel = 8'h00;
    wait_change(20, n, to);
    check("release_first_interval", n, 10);
    check("release_first_value", envelope, 8'h87);
    for (int lv = 8'h87; lv > 0; lv--) begin
      v = 8'(lv);
      wait_change(400, n, to);
      check($sformatf("release_interval_%0h", lv), n, 9 * ref_exp(v));
      check($sformatf("release_value_%0h", lv), envelope, lv - 1);
    end
    tick(1000);
    check("release_floor_hold", envelope, 8'h00);
    check("release_floor_state", dut.state, RELEASE);

    // Attack at P=32 up to 0x40, then toggle the gate low and high.
    att_dec = 8'h10;
    sus_rel = 8'hf0;
    gate    = 1'b1;
    wait_change(40, n, to);
    check("attack32_first_interval", n, 33);
    for (int lv = 1; lv < 8'h40; lv++) begin
      wait_change(40, n, to);
      if (n != 32 || envelope != 8'(lv + 1))
        check($sformatf("attack32_step_%0h", lv), {n[23:0], envelope},
              {24'd32, 8'(lv + 1)});
    end
    check("attack32_reached_40", envelope, 8'h40);
    gate = 1'b0;
    tick(5);
    check("toggle_low_env", envelope, 8'h40);
    check("toggle_low_state", dut.state, RELEASE);
    gate = 1'b1;
    tick(32);
    check("retrigger_before_step", envelope, 8'h40);
    tick(1);
    check("retrigger_first_step", envelope, 8'h41);

    // Rate count (20) above new period (9) must clear, not wrap.
    tick(20);
    att_dec = 8'h00;
    wait_change(40, n, to);
    check("rate_shrink_interval", n, 10);
    check("rate_shrink_value", envelope, 8'h42);

    // Climb to 0xFF then decay toward 0x00; stop at 0xC0 and reset.
    sus_rel = 8'h00;
    n = 0;
    while (!(envelope == 8'hc0 && dut.state == DECAY_SUSTAIN) && n < 4000) begin
      tick(1);
      n++;
    end
    check("reach_c0_decay", envelope, 8'hc0);
    check("reach_c0_state", dut.state, DECAY_SUSTAIN);
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    check("midrun_reset_env", envelope, 8'h00);
    check("midrun_reset_state", dut.state, RELEASE);
    tick(200);
    check("held_gate_no_attack_env", envelope, 8'h00);
    check("held_gate_no_attack_state", dut.state, RELEASE);
    gate = 1'b0;
    tick(2);
    gate = 1'b1;
    tick(9);
    check("rekey_before_step", envelope, 8'h00);
    tick(1);
    check("rekey_first_step", envelope, 8'h01);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
